buzzer_arbiter: RTL and testbench
=================================

BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 Parameter: TICK_DIV, 100000, clk cycles per 1 ms duration tick (100 MHz clk).
REQ-002 Parameter: GAP_MS, 100, silent gap in ms between repeats of one request.
REQ-003 Port: clk  input  1  system clock, all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  3  per-requester request level; bit 0 = finish alarm (highest priority), bit 1 = keypad click, bit 2 = power-on jingle.
REQ-006 Port: req_div  input  66  three packed 22-bit half-period dividers; slice [22*i+21:22*i] belongs to requester i.
REQ-007 Port: req_dur  input  30  three packed 10-bit tone durations in ms; slice [10*i+9:10*i].
REQ-008 Port: req_rep  input  12  three packed 4-bit repeat counts; slice [4*i+3:4*i].
REQ-009 Port: mute  input  1  forces buzzer low; sequencing continues unchanged.
REQ-010 Port: ack  output  3  one-cycle pulse: request i accepted and parameters latched.
REQ-011 Port: done  output  3  one-cycle pulse: request i completed all repeats.
REQ-012 Port: aborted  output  3  one-cycle pulse: request i preempted before completion.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.
REQ-014 Port: grant_id  output  2  id of the request currently playing; 2'd3 when IDLE.
REQ-015 Port: buzzer  output  1  registered square-wave drive to the piezo.

Function
REQ-016 The FSM SHALL have three states: IDLE, TONE and GAP.
REQ-017 In IDLE, at the clock edge where any req bit is high, the FSM SHALL latch div, dur and rep of the lowest-numbered asserted requester, set grant_id, pulse ack[id] in the following cycle, and enter TONE.
REQ-018 A requester SHALL deassert req in the cycle its ack is high; req is sampled only in IDLE, except for the preemption case in REQ-024.
REQ-019 Duration SHALL be timed by a ms prescaler restarted on every entry to TONE or GAP; TONE lasts exactly max(dur,1)*TICK_DIV cycles and GAP lasts exactly GAP_MS*TICK_DIV cycles.
REQ-020 In TONE, buzzer SHALL toggle every div cycles, with the toggle counter and the phase reset to 0 on TONE entry; div==0 SHALL give a silent tone whose timing is unchanged.
REQ-021 An effective repeat count of max(rep,1) SHALL apply; at TONE end the FSM SHALL go to GAP if more repeats remain, otherwise pulse done[id] and return to IDLE.
REQ-022 At GAP end the FSM SHALL decrement the remaining-repeat count and re-enter TONE.
REQ-023 buzzer SHALL be 0 in IDLE, in GAP and whenever mute is high, and SHALL lag the internal tone by one register stage.
REQ-024 If req[0] is high while the FSM is in TONE or GAP serving id 1 or 2, the FSM SHALL pulse aborted[id], latch requester 0's parameters, pulse ack[0] and restart TONE in the same way as REQ-017.
REQ-025 Requester 0 SHALL never be preempted, and requesters 1 and 2 SHALL never preempt each other.
REQ-026 Completion and a new request in the same cycle: done SHALL pulse, IDLE SHALL last at least one cycle, and the request SHALL then be granted.
REQ-027 At most one bit of ack, done or aborted SHALL be high in any cycle.

Reset
REQ-028 Reset SHALL force state IDLE, grant_id=3, and all of ack, done, aborted, busy and buzzer to 0, and SHALL clear all counters and latched parameters.
REQ-029 Reset asserted mid-tone SHALL silence buzzer immediately and produce no done or aborted pulse.

Structure
REQ-030 A shared package buzzer_pkg SHALL hold the state encoding, requester id constants (ID_ALARM=0, ID_CLICK=1, ID_POWER=2, ID_NONE=3) and the standard divider constants for 1, 1.3, 2, 3 and 4 kHz.
REQ-031 The divider counter and toggle logic SHALL be a sub-module buzzer_tone_gen with ports clk, reset, en, div and tone.

Verification (TICK_DIV=10, GAP_MS=2)
REQ-032 req=3'b010, div=5, dur=3, rep=1 -> ack[1] one cycle, buzzer period 10 cycles for 30 cycles, done[1], busy falls, grant_id=3.
REQ-033 req[2], dur=2, rep=3 -> three 20-cycle tones separated by two 20-cycle silent gaps, then exactly one done[2].
REQ-034 req=3'b110 together in IDLE -> ack[1] only; req[2] held -> granted after done[1] plus one IDLE cycle.
REQ-035 req[0] asserted during GAP of id 2 -> aborted[2], ack[0] next cycle, grant_id=0; a later req[1] does not preempt.
REQ-036 mute high during a tone, and reset mid-tone -> buzzer 0 while timing and done are unchanged; reset gives all outputs at reset values with no pulses.
REQ-037 div=0, dur=0, rep=0 -> silent 10-cycle TONE followed by done.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer arbiter: FSM encoding, requester ids,
// field widths and standard half-period dividers for a 100 MHz clock.
package buzzer_pkg;

  localparam int NREQ  = 3;
  localparam int DIV_W = 22;
  localparam int DUR_W = 10;
  localparam int REP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] ID_ALARM = 2'd0;
  localparam logic [1:0] ID_CLICK = 2'd1;
  localparam logic [1:0] ID_POWER = 2'd2;
  localparam logic [1:0] ID_NONE  = 2'd3;

  // Half-period in clk cycles at 100 MHz.
  localparam logic [DIV_W-1:0] DIV_1KHZ  = 22'd50000;
  localparam logic [DIV_W-1:0] DIV_1K3HZ = 22'd38462;
  localparam logic [DIV_W-1:0] DIV_2KHZ  = 22'd25000;
  localparam logic [DIV_W-1:0] DIV_3KHZ  = 22'd16667;
  localparam logic [DIV_W-1:0] DIV_4KHZ  = 22'd12500;

  // Fixed priority: lowest-numbered asserted requester wins.
  function automatic logic [1:0] pick_id(input logic [NREQ-1:0] req);
    if (req[0])      return ID_ALARM;
    else if (req[1]) return ID_CLICK;
    else if (req[2]) return ID_POWER;
    else             return ID_NONE;
  endfunction

  function automatic logic [NREQ-1:0] id_onehot(input logic [1:0] id);
    return NREQ'(3'b001 << id);
  endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave generator: toggles tone every div enabled cycles; counter and
// phase clear whenever en is low, and div == 0 holds the tone silent.
module buzzer_tone_gen
  import buzzer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tone
);

  logic [DIV_W-1:0] cnt;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (div != '0) begin
      if (cnt == div - DIV_W'(1)) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Priority arbiter for three buzzer requesters: plays tone/gap sequences with
// ms-accurate timing and lets the finish alarm preempt the other two.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS   = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DIV_W-1:0] req_div,
  input  logic [NREQ*DUR_W-1:0] req_dur,
  input  logic [NREQ*REP_W-1:0] req_rep,
  input  logic                  mute,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       aborted,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic                  buzzer
);

  localparam int                 CNT_W    = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]   GAP_LEN  = DUR_W'(GAP_MS);

  state_e           state, state_next;
  logic [DIV_W-1:0] div_q;
  logic [DUR_W-1:0] dur_q;
  logic [REP_W-1:0] rep_left;
  logic [CNT_W-1:0] ms_cnt;
  logic [DUR_W-1:0] ms_left;
  logic             ack_pend;

  logic [1:0]       sel_id;
  logic [DIV_W-1:0] sel_div;
  logic [DUR_W-1:0] sel_dur, eff_dur;
  logic [REP_W-1:0] sel_rep, eff_rep;
  logic             ms_end;
  logic             load, preempt, fin, tone_start, gap_start, gap_end;
  logic             tone_en, tone;

  always_comb begin
    sel_id = pick_id(req);
    case (sel_id)
      ID_CLICK: begin
        sel_div = req_div[DIV_W +: DIV_W];
        sel_dur = req_dur[DUR_W +: DUR_W];
        sel_rep = req_rep[REP_W +: REP_W];
      end
      ID_POWER: begin
        sel_div = req_div[2*DIV_W +: DIV_W];
        sel_dur = req_dur[2*DUR_W +: DUR_W];
        sel_rep = req_rep[2*REP_W +: REP_W];
      end
      default: begin
        sel_div = req_div[DIV_W-1:0];
        sel_dur = req_dur[DUR_W-1:0];
        sel_rep = req_rep[REP_W-1:0];
      end
    endcase
    eff_dur = (sel_dur == '0) ? DUR_W'(1) : sel_dur;
    eff_rep = (sel_rep == '0) ? REP_W'(1) : sel_rep;
  end

  assign ms_end = (ms_cnt == CNT_LAST) && (ms_left == DUR_W'(1));

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    preempt    = 1'b0;
    fin        = 1'b0;
    tone_start = 1'b0;
    gap_start  = 1'b0;
    gap_end    = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          load       = 1'b1;
          tone_start = 1'b1;
          state_next = TONE;
        end
      end
      TONE, GAP: begin
        if (req[0] && grant_id != ID_ALARM) begin
          preempt    = 1'b1;
          load       = 1'b1;
          tone_start = 1'b1;
          state_next = TONE;
        end else if (ms_end) begin
          if (state == GAP) begin
            gap_end    = 1'b1;
            tone_start = 1'b1;
            state_next = TONE;
          end else if (rep_left > REP_W'(1)) begin
            gap_start  = 1'b1;
            state_next = GAP;
          end else begin
            fin        = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Clearing the generator on the entry edge restarts phase even on TONE->TONE.
  assign tone_en = (state_next == TONE) && !tone_start;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: all state here is plain registers (no memories), so all of it is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      dur_q    <= '0;
      rep_left <= '0;
      ms_cnt   <= '0;
      ms_left  <= '0;
      ack_pend <= 1'b0;
      grant_id <= ID_NONE;
      ack      <= '0;
      done     <= '0;
      aborted  <= '0;
      buzzer   <= 1'b0;
    end else begin
      ack      <= '0;
      done     <= '0;
      aborted  <= '0;
      ack_pend <= preempt;
      buzzer   <= tone & tone_en & ~mute;

      // A preempting alarm is acknowledged the cycle after the abort pulse.
      if (ack_pend) ack <= id_onehot(ID_ALARM);
      if (load) begin
        div_q    <= sel_div;
        dur_q    <= eff_dur;
        rep_left <= eff_rep;
        grant_id <= sel_id;
        if (!preempt) ack <= id_onehot(sel_id);
      end
      if (preempt) aborted <= id_onehot(grant_id);
      if (fin) begin
        done     <= id_onehot(grant_id);
        grant_id <= ID_NONE;
      end
      if (gap_end) rep_left <= rep_left - REP_W'(1);

      if (tone_start || gap_start) begin
        ms_cnt  <= '0;
        ms_left <= gap_start ? GAP_LEN : (load ? eff_dur : dur_q);
      end else if (state != IDLE) begin
        if (ms_cnt == CNT_LAST) begin
          ms_cnt  <= '0;
          ms_left <= ms_left - DUR_W'(1);
        end else begin
          ms_cnt <= ms_cnt + CNT_W'(1);
        end
      end
    end
  end

  buzzer_tone_gen u_tone_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tone_en),
    .div   (div_q),
    .tone  (tone)
  );

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed testbench for buzzer_arbiter with TICK_DIV=10 and GAP_MS=2;
// inputs change and outputs are sampled on the falling clock edge.
module tb_buzzer_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [65:0] req_div = '0;
  logic [29:0] req_dur = '0;
  logic [11:0] req_rep = '0;
  logic        mute = 1'b0;
  logic [2:0]  ack, done, aborted;
  logic        busy;
  logic [1:0]  grant_id;
  logic        buzzer;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buzzer_arbiter #(.TICK_DIV(10), .GAP_MS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_div  (req_div),
    .req_dur  (req_dur),
    .req_rep  (req_rep),
    .mute     (mute),
    .ack      (ack),
    .done     (done),
    .aborted  (aborted),
    .busy     (busy),
    .grant_id (grant_id),
    .buzzer   (buzzer)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_slot(input int id, input logic [21:0] d, input logic [9:0] du,
                          input logic [3:0] r);
    req_div[22*id +: 22] = d;
    req_dur[10*id +: 10] = du;
    req_rep[4*id +: 4]   = r;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({ack, done, aborted, busy, grant_id, buzzer} !== {3'b0, 3'b0, 3'b0, 1'b0, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b done=%b ab=%b busy=%b gid=%0d bz=%b exp 0/0/0/0/3/0",
               ack, done, aborted, busy, grant_id, buzzer);
    end
    reset = 1'b0;
    tick();
  endtask

  // Click: div=5 -> period 10, dur=3 -> 30 TONE cycles, then done[1].
  task automatic test_click();
    logic [29:0] got, exp;
    int busy_bad = 0;
    set_slot(1, 22'd5, 10'd3, 4'd1);
    req = 3'b010;
    tick();
    checks++;
    if (ack !== 3'b010 || grant_id !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL click_ack got ack=%b gid=%0d busy=%b exp 010/1/1", ack, grant_id, busy);
    end
    req = 3'b000;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      got[k] = buzzer;
      exp[k] = (k >= 1) ? (((k - 1) / 5) % 2 == 1) : 1'b0;
      if (busy !== 1'b1) busy_bad++;
      if (k == 1) begin
        checks++;
        if (ack !== 3'b000) begin
          errors++;
          $display("FAIL click_ack_width got %b exp 000", ack);
        end
      end
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL click_wave got %b exp %b", got, exp);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL click_busy got %0d low cycles exp 0", busy_bad);
    end
    tick();
    checks++;
    if (done !== 3'b010 || busy !== 1'b0 || grant_id !== 2'd3 || buzzer !== 1'b0) begin
      errors++;
      $display("FAIL click_done got done=%b busy=%b gid=%0d bz=%b exp 010/0/3/0",
               done, busy, grant_id, buzzer);
    end
    tick();
    checks++;
    if (done !== 3'b000) begin
      errors++;
      $display("FAIL click_done_width got %b exp 000", done);
    end
  endtask

  // Power jingle: three 20-cycle tones with two 20-cycle silent gaps.
  task automatic test_power();
    logic [99:0] got, exp;
    int busy_bad = 0;
    int done_early = 0;
    set_slot(2, 22'd1, 10'd2, 4'd3);
    req = 3'b100;
    tick();
    checks++;
    if (ack !== 3'b100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL power_ack got ack=%b gid=%0d exp 100/2", ack, grant_id);
    end
    req = 3'b000;
    for (int t = 0; t < 100; t++) begin
      if (t > 0) tick();
      got[t] = buzzer;
      exp[t] = ((t / 20) % 2 == 0 && (t % 20) >= 1) ? (((t % 20) - 1) % 2 == 1) : 1'b0;
      if (busy !== 1'b1) busy_bad++;
      if (done !== 3'b000) done_early++;
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL power_wave got %h exp %h", got, exp);
    end
    checks++;
    if (busy_bad != 0 || done_early != 0) begin
      errors++;
      $display("FAIL power_busy got busy_low=%0d early_done=%0d exp 0/0", busy_bad, done_early);
    end
    tick();
    checks++;
    if (done !== 3'b100 || busy !== 1'b0) begin
      errors++;
      $display("FAIL power_done got done=%b busy=%b exp 100/0", done, busy);
    end
    tick();
    checks++;
    if (done !== 3'b000) begin
      errors++;
      $display("FAIL power_single_done got %b exp 000", done);
    end
  endtask

  // Simultaneous click and jingle: click first, jingle after one IDLE cycle.
  task automatic test_priority();
    set_slot(1, 22'd2, 10'd1, 4'd1);
    set_slot(2, 22'd4, 10'd1, 4'd1);
    req = 3'b110;
    tick();
    checks++;
    if (ack !== 3'b010 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL prio_ack got ack=%b gid=%0d exp 010/1", ack, grant_id);
    end
    req = 3'b100;
    repeat (10) tick();
    checks++;
    if (done !== 3'b010 || ack !== 3'b000 || busy !== 1'b0 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL prio_idle got done=%b ack=%b busy=%b gid=%0d exp 010/000/0/3",
               done, ack, busy, grant_id);
    end
    tick();
    checks++;
    if (ack !== 3'b100 || grant_id !== 2'd2 || busy !== 1'b1 || done !== 3'b000) begin
      errors++;
      $display("FAIL prio_second got ack=%b gid=%0d busy=%b done=%b exp 100/2/1/000",
               ack, grant_id, busy, done);
    end
    req = 3'b000;
    repeat (10) tick();
    checks++;
    if (done !== 3'b100) begin
      errors++;
      $display("FAIL prio_second_done got %b exp 100", done);
    end
    tick();
  endtask

  // Alarm preempts jingle in its gap; a later click waits for the alarm.
  task automatic test_preempt();
    int bad = 0;
    set_slot(2, 22'd3, 10'd1, 4'd2);
    set_slot(0, 22'd2, 10'd2, 4'd1);
    set_slot(1, 22'd2, 10'd1, 4'd1);
    req = 3'b100;
    tick();
    checks++;
    if (ack !== 3'b100) begin
      errors++;
      $display("FAIL pre_ack2 got %b exp 100", ack);
    end
    req = 3'b000;
    repeat (15) tick();
    checks++;
    if (buzzer !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL pre_gap got bz=%b busy=%b gid=%0d exp 0/1/2", buzzer, busy, grant_id);
    end
    req = 3'b001;
    tick();
    checks++;
    if (aborted !== 3'b100 || ack !== 3'b000 || grant_id !== 2'd0 || done !== 3'b000) begin
      errors++;
      $display("FAIL pre_abort got ab=%b ack=%b gid=%0d done=%b exp 100/000/0/000",
               aborted, ack, grant_id, done);
    end
    tick();
    checks++;
    if (ack !== 3'b001 || aborted !== 3'b000) begin
      errors++;
      $display("FAIL pre_ack0 got ack=%b ab=%b exp 001/000", ack, aborted);
    end
    req = 3'b000;
    repeat (3) tick();
    req = 3'b010;
    for (int t = 21; t <= 35; t++) begin
      tick();
      if (aborted !== 3'b000 || grant_id !== 2'd0 || done !== 3'b000 || ack !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pre_no_preempt got %0d bad cycles exp 0", bad);
    end
    tick();
    checks++;
    if (done !== 3'b001 || busy !== 1'b0 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL pre_alarm_done got done=%b busy=%b gid=%0d exp 001/0/3", done, busy, grant_id);
    end
    tick();
    checks++;
    if (ack !== 3'b010 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL pre_click_ack got ack=%b gid=%0d exp 010/1", ack, grant_id);
    end
    req = 3'b000;
    repeat (10) tick();
    checks++;
    if (done !== 3'b010) begin
      errors++;
      $display("FAIL pre_click_done got %b exp 010", done);
    end
    tick();
  endtask

  // Mute silences but keeps timing; reset mid-tone clears everything at once.
  task automatic test_mute_reset();
    logic any_bz = 1'b0;
    logic [2:0] pulses = '0;
    int busy_bad = 0;
    set_slot(1, 22'd5, 10'd3, 4'd1);
    mute = 1'b1;
    tick();
    req = 3'b010;
    tick();
    req = 3'b000;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      any_bz |= buzzer;
    end
    tick();
    checks++;
    if (any_bz !== 1'b0 || done !== 3'b010) begin
      errors++;
      $display("FAIL mute got any_bz=%b done=%b exp 0/010", any_bz, done);
    end
    mute = 1'b0;
    tick();
    req = 3'b010;
    tick();
    req = 3'b000;
    repeat (8) tick();
    checks++;
    if (buzzer !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_tone got %b exp 1", buzzer);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({ack, done, aborted, busy, grant_id, buzzer} !== {3'b0, 3'b0, 3'b0, 1'b0, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid got ack=%b done=%b ab=%b busy=%b gid=%0d bz=%b exp 0/0/0/0/3/0",
               ack, done, aborted, busy, grant_id, buzzer);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      pulses |= ack | done | aborted;
      if (busy !== 1'b0 || buzzer !== 1'b0) busy_bad++;
    end
    checks++;
    if (pulses !== 3'b000 || busy_bad != 0) begin
      errors++;
      $display("FAIL rst_after got pulses=%b active=%0d exp 000/0", pulses, busy_bad);
    end
  endtask

  // Zero div/dur/rep: one silent 10-cycle tone, then done.
  task automatic test_silent();
    logic any_bz = 1'b0;
    int busy_bad = 0;
    set_slot(1, 22'd0, 10'd0, 4'd0);
    req = 3'b010;
    tick();
    checks++;
    if (ack !== 3'b010) begin
      errors++;
      $display("FAIL silent_ack got %b exp 010", ack);
    end
    req = 3'b000;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      any_bz |= buzzer;
      if (busy !== 1'b1) busy_bad++;
    end
    tick();
    checks++;
    if (any_bz !== 1'b0 || busy_bad != 0 || done !== 3'b010 || busy !== 1'b0) begin
      errors++;
      $display("FAIL silent got bz=%b busy_low=%0d done=%b busy=%b exp 0/0/010/0",
               any_bz, busy_bad, done, busy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_click();
    test_power();
    test_priority();
    test_preempt();
    test_mute_reset();
    test_silent();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
